// File: rtl/serial_pkg.sv
// Shared serial-line types and constants for the
// frequency meter's UART path (sequencer + transmitter).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA,
    STOP_BIT
  } tx_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned MAX_BYTES  = 4;
  localparam int unsigned FRAME_BITS = 10;

  localparam int unsigned CLK_FREQ_DEF = 50_000_000;
  localparam int unsigned BAUD_DEF     = 115200;

  // Byte counts above MAX_BYTES are clamped.
  function automatic logic [2:0] eff_bytes(
    input logic [2:0] b
  );
    return (b > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : b;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, pulses bit_done on the last.
// Ports: clk, rst_n (async low), restart (hold at 0), bit_done (pulse).
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done
);

  localparam int unsigned W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign bit_done = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/word_uart_tx.sv
// Word-level 8N1 transmitter: sends 1..4 bytes of a word, LSB byte first.
// Ports: clk, rst_n, start/busy handshake, word[31:0], bytes[2:0], TxD.
module word_uart_tx
  import serial_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEF,
  parameter int unsigned BAUD         = BAUD_DEF,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  input  logic [31:0] word,
  input  logic [2:0]  bytes,
  output logic        TxD
);

  tx_state_t   state;
  logic [31:0] shreg;
  logic [2:0]  nbytes;
  logic [2:0]  bit_idx;
  logic        bit_done;
  logic [2:0]  eff;

  assign eff = eff_bytes(bytes);

  // Counter is held at zero while idle, so every bit
  // cell after acceptance is exactly CLKS_PER_BIT long.
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state == IDLE),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      nbytes  <= '0;
      bit_idx <= '0;
      busy    <= 1'b0;
      TxD     <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          TxD <= 1'b1;
          // busy high in IDLE only follows a zero-byte
          // request; drop it and skip sampling this cycle.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            shreg  <= word;
            nbytes <= eff;
            busy   <= 1'b1;
            if (eff != 3'd0) begin
              state <= START_BIT;
              TxD   <= 1'b0;
            end
          end
        end
        START_BIT: begin
          if (bit_done) begin
            state   <= DATA;
            bit_idx <= '0;
            TxD     <= shreg[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            shreg <= {1'b0, shreg[31:1]};
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP_BIT;
              TxD   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              TxD     <= shreg[1];
            end
          end
        end
        STOP_BIT: begin
          if (bit_done) begin
            nbytes <= nbytes - 1'b1;
            if (nbytes == 3'd1) begin
              state <= IDLE;
              busy  <= 1'b0;
              TxD   <= 1'b1;
            end else begin
              state <= START_BIT;
              TxD   <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          TxD   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_uart_tx.sv
// Testbench for word_uart_tx: cycle-accurate frame model plus
// directed literal checks and randomized transfers.
module tb_word_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] word = '0;
  logic [2:0]  bytes = '0;
  logic        TxD;

  int total = 0;
  int bad = 0;

  word_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .busy (busy),
    .word (word),
    .bytes(bytes),
    .TxD  (TxD)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: on acceptance, the whole transfer is laid
  // out as a per-cycle list of {busy, TxD} pairs.
  logic [1:0] q[$];
  logic       exp_busy = 1'b0;
  logic       exp_txd = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    int n;
    logic b;
    if (!rst_n) begin
      q.delete();
      exp_busy = 1'b0;
      exp_txd  = 1'b1;
    end else begin
      if (!exp_busy && start) begin
        n = (bytes > 3'd4) ? 4 : int'(bytes);
        if (n == 0) q.push_back(2'b11);
        for (int f = 0; f < n; f++) begin
          for (int c = 0; c < 10; c++) begin
            if (c == 0) b = 1'b0;
            else if (c == 9) b = 1'b1;
            else b = word[8*f + c - 1];
            for (int k = 0; k < CPB; k++) q.push_back({1'b1, b});
          end
        end
      end
      if (q.size() > 0) begin
        {exp_busy, exp_txd} = q.pop_front();
      end else begin
        exp_busy = 1'b0;
        exp_txd  = 1'b1;
      end
    end
  end

  // Per-cycle comparison plus capture of TxD while busy.
  logic cap[$];

  always @(negedge clk) begin
    chk("busy_cyc", 64'(busy), 64'(exp_busy));
    chk("txd_cyc", 64'(TxD), 64'(exp_txd));
    if (busy) cap.push_back(TxD);
  end

  task automatic wait_busy(input logic lvl, input int lim);
    int i;
    i = 0;
    while (busy !== lvl && i < lim) begin
      @(negedge clk);
      i++;
    end
    if (busy !== lvl) begin
      total++;
      bad++;
      $display("FAIL wait_busy actual=%0b required=%0b", busy, lvl);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [2:0] b);
    @(negedge clk);
    word  = w;
    bytes = b;
    start = 1'b1;
    @(negedge clk);
    wait_busy(1'b1, 20);
    start = 1'b0;
    wait_busy(1'b0, 400);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frames(string nm, int n, logic [31:0] w);
    logic [7:0] d;
    chk({nm, "_len"}, 64'(cap.size()), 64'(n * 10 * CPB));
    if (cap.size() >= n * 10 * CPB) begin
      for (int f = 0; f < n; f++) begin
        chk({nm, "_startbit"}, 64'(cap[f*40 + 2]), 64'd0);
        for (int c = 0; c < 8; c++) d[c] = cap[f*40 + (c+1)*CPB + 2];
        chk({nm, "_byte"}, 64'(d), 64'(w[8*f +: 8]));
        chk({nm, "_stopbit"}, 64'(cap[f*40 + 9*CPB + 2]), 64'd1);
      end
    end
  endtask

  task automatic check_cells(string nm, logic [19:0] exp, int nc);
    logic [19:0] act;
    act = '0;
    if (cap.size() >= nc * CPB) begin
      for (int c = 0; c < nc; c++) act[nc-1-c] = cap[c*CPB + 1];
    end
    chk(nm, 64'(act), 64'(exp));
  endtask

  initial begin
    int gap;
    #12;
    chk("reset_txd", 64'(TxD), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cap.delete();
    send(32'h0000_01FF, 3'd2);
    chk("two_len", 64'(cap.size()), 64'd80);
    check_cells("two_cells", 20'b0111111111_0100000001, 20);

    cap.delete();
    send(32'h1234_5678, 3'd4);
    check_frames("order", 4, 32'h1234_5678);

    cap.delete();
    send(32'hDEAD_BEEF, 3'd0);
    chk("zero_len", 64'(cap.size()), 64'd1);
    if (cap.size() > 0) chk("zero_txd", 64'(cap[0]), 64'd1);

    cap.delete();
    send(32'hAABB_CCDD, 3'd7);
    check_frames("clamp", 4, 32'hAABB_CCDD);

    // Start held high across two transfers; word changes mid-flight.
    cap.delete();
    @(negedge clk);
    word  = 32'h11;
    bytes = 3'd1;
    start = 1'b1;
    @(negedge clk);
    wait_busy(1'b1, 20);
    repeat (10) @(negedge clk);
    word = 32'h22;
    wait_busy(1'b0, 400);
    gap = 0;
    while (!busy && gap < 20) begin
      gap++;
      @(negedge clk);
    end
    chk("b2b_gap", 64'(gap), 64'd1);
    start = 1'b0;
    wait_busy(1'b0, 400);
    check_frames("b2b", 2, 32'h2211);

    // Reset during data bit 3 of the first byte.
    @(negedge clk);
    word  = 32'h1234_5678;
    bytes = 3'd4;
    start = 1'b1;
    @(negedge clk);
    wait_busy(1'b1, 20);
    start = 1'b0;
    repeat (17) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_txd", 64'(TxD), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cap.delete();
    send(32'h55, 3'd1);
    check_cells("post_rst", 20'(10'b0101010101), 10);
    check_frames("post_rst", 1, 32'h55);

    // Randomized transfers; the model checks every cycle.
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      word  = $urandom;
      bytes = 3'($urandom_range(0, 7));
      start = 1'b1;
      repeat ($urandom_range(1, 120)) begin
        @(negedge clk);
        word  = $urandom;
        bytes = 3'($urandom_range(0, 7));
      end
      start = 1'b0;
      wait_busy(1'b0, 400);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/word_uart_tx.md
Name: word_uart_tx

Overview:
- Word-level UART transmitter that sits directly downstream of the serial framing sequencer.
- It accepts one 32-bit word plus a byte count under a start/busy handshake.
- It emits 1 to 4 bytes of that word, least-significant byte first, as back-to-back 8N1 frames on TxD.
- It is the only block that drives the physical serial line of the frequency meter.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (434): clock cycles per serial bit. Legal range 2..65535. Benches override it to 4.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  level request; sampled only while idle
- busy  output  1  high from the cycle after acceptance until the last stop bit completes
- word  input  32  data word, captured on acceptance
- bytes  input  3  number of bytes to send, captured on acceptance
- TxD  output  1  serial line; idles high

Behaviour:
- Reset (async, rst_n=0): TxD=1, busy=0, all counters 0, FSM=IDLE. Mid-transfer reset aborts at once: TxD returns high in the reset cycle and no partial byte resumes.
- Acceptance: in IDLE with start=1 at a clk edge:
  - word goes into a 32-bit shift register.
  - Effective count is latched: bytes 1..4 as given; 5..7 clamped to 4.
  - Next cycle busy=1 and TxD=0 (start bit begins).
- bytes=0: busy=1 for exactly one cycle, TxD stays 1, then back to IDLE. This lets the upstream handshake complete.
- start while busy: ignored. word and bytes are not re-sampled.
- start is level-sensitive. If start is still high in the first IDLE cycle after busy falls, a new transfer is accepted.
- The upstream sequencer holds start until it sees busy=1, then drops it. This is compatible with the rule above.
- FSM: IDLE -> START_BIT -> DATA -> STOP_BIT, then:
  - STOP_BIT -> START_BIT if bytes remain;
  - STOP_BIT -> IDLE otherwise.
- Bit timing: each bit state holds TxD for exactly CLKS_PER_BIT cycles.
  - A baud counter counts 0..CLKS_PER_BIT-1 and restarts on every state change.
  - Its width is $clog2(CLKS_PER_BIT).
- DATA: 8 bits, LSB first. A bit index counts 0..7; TxD = shift_reg[0]. The register shifts right by 1 at each bit boundary.
- STOP_BIT: TxD=1 for CLKS_PER_BIT cycles.
  - Byte counter decrements; the shift register has already consumed 8 bits, so the next byte sits in [7:0].
  - No idle gap between consecutive frames.
- busy falls the cycle after the final stop bit's last cycle. TxD is already 1 and stays 1.
- Transfer duration: busy high for exactly N*10*CLKS_PER_BIT cycles, where N = effective byte count (1..4).
- All outputs are registered, with no combinational path from start to busy or TxD.

Decomposition:
- Package serial_pkg holds:
  - tx_state_t enum {IDLE, START_BIT, DATA, STOP_BIT};
  - constants DATA_BITS=8, MAX_BYTES=4, FRAME_BITS=10;
  - default CLK_FREQ/BAUD localparams, shared with the sequencer.
- One sub-module: uart_baud_counter. It takes clk, rst_n and a restart input, and outputs a bit_done pulse on count CLKS_PER_BIT-1.
- Byte and bit sequencing stay in word_uart_tx.

Test Plan:
- All scenarios use CLKS_PER_BIT=4.
- Two-byte frame: word=0x0000_01FF, bytes=2, start pulse held until busy -> TxD bit cells: 0,1×8,1 then 0,1,0,0,0,0,0,0,0,1. busy high exactly 80 cycles.
- Byte order: word=0x1234_5678, bytes=4 -> decoded bytes 0x78,0x56,0x34,0x12 in order. busy high 160 cycles, no idle cells between frames.
- Degenerate counts:
  - bytes=0 -> busy high 1 cycle, TxD constant 1.
  - bytes=7, word=0xAABB_CCDD -> exactly 4 bytes DD,CC,BB,AA sent, 160 cycles.
- Busy-time isolation and back-to-back: start held high throughout, word changed 0x11->0x22 mid-transfer -> first transfer sends 0x11 only. Second transfer is accepted the first IDLE cycle after busy falls and sends 0x22 with no extra gap.
- Reset mid-operation: assert rst_n=0 during DATA bit 3 of byte 1 -> TxD=1 and busy=0 asynchronously. After release, a start with word=0x55, bytes=1 yields a clean single frame 0,1,0,1,0,1,0,1,0,1.
